five_way_rr_arbiter: RTL
========================

FIVE_WAY_RR_ARBITER -- requirements
Module: five_way_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive cycles one requester SHALL hold a grant; 0 SHALL mean unlimited.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port req  input  5  request lines; bit 0 = input a of the downstream five-to-one mux, ..., bit 4 = input e.
REQ-005 Port grant  output  5  one-hot grant, registered; all zeros when no grant.
REQ-006 Port sel  output  3  mux select, registered; index of the granted requester (0..4).
REQ-007 Port busy  output  1  high while any grant is active.

Function
REQ-008 The block SHALL be a three-state FSM: IDLE, GRANT, GAP.
REQ-009 The block SHALL hold an internal 3-bit priority pointer ptr in range 0..4.
REQ-010 In IDLE with req != 0, the block SHALL select the first set req bit searching ptr, ptr+1, ... modulo 5 (4 wraps to 0).
REQ-011 At the next rising edge it SHALL enter GRANT, with grant = one-hot(g), sel = g, busy = 1, and hold counter = 1.
REQ-012 Grant latency SHALL be exactly one edge from the req sample; there SHALL be no combinational path from req to any output.
REQ-013 In IDLE with req == 0, the block SHALL remain in IDLE with all outputs at their reset values.
REQ-014 In GRANT, grant SHALL stay stable and the hold counter SHALL increment each edge while req[g] = 1 and (MAX_HOLD == 0 or counter < MAX_HOLD).
REQ-015 In GRANT, when req[g] = 0 or counter == MAX_HOLD (MAX_HOLD != 0), the next edge SHALL enter GAP with grant = 0, busy = 0, sel = 0, and ptr = (g+1) mod 5.
REQ-016 A simultaneous req drop and timeout SHALL count as a single release: one GAP cycle and a single ptr advance.
REQ-017 Changes on non-granted req bits during GRANT SHALL be ignored; there SHALL be no preemption.
REQ-018 GAP SHALL last exactly one cycle, then go to IDLE; req is not sampled for arbitration during GAP.
REQ-019 A requester released by timeout that still requests SHALL compete again from IDLE under the advanced ptr.
REQ-020 The hold counter SHALL be wide enough for MAX_HOLD without wrapping; with MAX_HOLD = 0 it SHALL saturate rather than wrap.
REQ-021 sel SHALL never take values 5..7.
REQ-022 grant SHALL never have more than one bit set.

Reset
REQ-023 While reset = 1, independent of clk, the block SHALL force state = IDLE, ptr = 0, hold counter = 0, grant = 5'b00000, sel = 3'd0, busy = 0.
REQ-024 Reset asserted mid-GRANT SHALL clear the grant immediately, with no clock edge required.
REQ-025 After reset deasserts, the first arbitration SHALL start from ptr = 0.

Verification (MAX_HOLD = 4 unless stated)
REQ-026 Single request: after reset, req = 5'b00100 -> next edge grant = 5'b00100, sel = 2, busy = 1; drop req -> next edge grant = 0 (GAP), then IDLE; ptr = 3.
REQ-027 Full contention: req = 5'b11111 held from reset -> grants go to indices 0, 1, 2, 3, 4, 0; each grant lasts 4 cycles followed by 1 GAP cycle.
REQ-028 Wrap-around: with ptr = 3, req = 5'b00011 -> grant = 5'b00001, sel = 0.
REQ-029 Async reset: reset pulsed mid-GRANT between clock edges -> grant = 0 and busy = 0 before the next edge; req = 5'b11111 afterwards -> grant index 0.
REQ-030 Simultaneous release: req[g] drops on the same edge the counter reaches 4 -> exactly one GAP cycle and ptr = g+1.
REQ-031 Unlimited hold: with MAX_HOLD = 0 and req = 5'b10000 held for 20 cycles -> grant = 5'b10000 and sel = 4 throughout, with no GAP cycle.

Source files
------------

// File: rtl/five_way_rr_arbiter.sv
// ============================================================================
// Module   : five_way_rr_arbiter
// Purpose  : Round-robin arbiter for a 5:1 mux with bounded hold and one GAP
//            cycle between grants; all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module five_way_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] req,
    output logic [4:0] grant,
    output logic [2:0] sel,
    output logic       busy
);

    // MAX_HOLD == 0 means unlimited; the counter then saturates instead of wrapping.
    localparam int CW = (MAX_HOLD == 0) ? 4 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] c_max_hold = CW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [2:0]    r_ptr, w_ptr_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [4:0]    r_grant, w_grant_nxt;
    logic [2:0]    r_sel, w_sel_nxt;
    logic          r_busy, w_busy_nxt;
    logic [3:0]    w_pick;
    logic          w_release;

    // Returns {found, index}; lower offsets from p overwrite higher ones.
    function automatic logic [3:0] rr_pick(input logic [4:0] r, input logic [2:0] p);
        logic [3:0] res;
        int         k;
        res = 4'd0;
        for (int i = 4; i >= 0; i--) begin
            k = (int'(p) + i) % 5;
            if (r[3'(k)]) res = {1'b1, 3'(k)};
        end
        return res;
    endfunction

    assign w_pick    = rr_pick(req, r_ptr);
    assign w_release = !req[r_sel] || ((MAX_HOLD != 0) && (r_cnt == c_max_hold));

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_busy_nxt  = r_busy;
        unique case (r_state)
            IDLE: begin
                w_grant_nxt = 5'd0;
                w_sel_nxt   = 3'd0;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                if (w_pick[3]) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = 5'b00001 << w_pick[2:0];
                    w_sel_nxt   = w_pick[2:0];
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = CW'(1);
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt = GAP;
                    w_grant_nxt = 5'd0;
                    w_sel_nxt   = 3'd0;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = (r_sel == 3'd4) ? 3'd0 : r_sel + 3'd1;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 5'd0;
                w_sel_nxt   = 3'd0;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= 3'd0;
            r_cnt   <= '0;
            r_grant <= 5'd0;
            r_sel   <= 3'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign grant = r_grant;
    assign sel   = r_sel;
    assign busy  = r_busy;

endmodule

`default_nettype wire
